// File: rtl/led_cfg_seq.sv
// LED driver configuration sequencer: captures a full register set on handshake and
// replays it as nine back-to-back register writes, then arms LEDDEXE.
module led_cfg_seq #(
  parameter int CLK_PASS = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] pwm_r,
  input  logic [7:0] pwm_g,
  input  logic [7:0] pwm_b,
  input  logic [7:0] prescale,
  input  logic [7:0] on_time,
  input  logic [7:0] off_time,
  input  logic [7:0] breathe_on,
  input  logic [7:0] breathe_off,
  input  logic [7:0] ctrl0,
  input  logic       exe_en,
  output logic       ledd_cs,
  output logic       ledd_den,
  output logic [3:0] ledd_addr,
  output logic [7:0] ledd_dat,
  output logic       ledd_exe,
  output logic       done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_ARM   = 2'd2;

  localparam logic [3:0] LAST_BEAT = 4'd8;

  // Register address issued for each beat index; indices past the last beat map to 0.
  function automatic logic [3:0] beat_addr(input logic [3:0] idx);
    logic [3:0] addr;
    case (idx)
      4'd0:    addr = 4'h9;
      4'd1:    addr = 4'hA;
      4'd2:    addr = 4'hB;
      4'd3:    addr = 4'h5;
      4'd4:    addr = 4'h6;
      4'd5:    addr = 4'h1;
      4'd6:    addr = 4'h2;
      4'd7:    addr = 4'h3;
      4'd8:    addr = 4'h8;
      default: addr = 4'h0;
    endcase
    return addr;
  endfunction

  // Byte selected by a beat index out of the beat-ordered register image.
  function automatic logic [7:0] beat_data(input logic [8:0][7:0] image,
                                           input logic [3:0]      idx);
    logic [7:0] dat;
    case (idx)
      4'd0:    dat = image[0];
      4'd1:    dat = image[1];
      4'd2:    dat = image[2];
      4'd3:    dat = image[3];
      4'd4:    dat = image[4];
      4'd5:    dat = image[5];
      4'd6:    dat = image[6];
      4'd7:    dat = image[7];
      4'd8:    dat = image[8];
      default: dat = 8'h00;
    endcase
    return dat;
  endfunction

  logic              clk_pass_unused_s;
  logic [8:0][7:0]   cfg_in_s;
  logic              accept_s;

  logic [1:0]        state_q, state_d;
  logic [3:0]        beat_q, beat_d;
  logic [8:0][7:0]   shadow_q, shadow_d;
  logic              exe_cap_q, exe_cap_d;
  logic              ready_q, ready_d;
  logic              cs_q, cs_d;
  logic              den_q, den_d;
  logic [3:0]        addr_q, addr_d;
  logic [7:0]        dat_q, dat_d;
  logic              exe_q, exe_d;
  logic              done_q, done_d;

  assign clk_pass_unused_s = (CLK_PASS != 0);

  // Inputs packed in beat order so index k is the byte written on beat k.
  assign cfg_in_s = {ctrl0, pwm_b, pwm_g, pwm_r, breathe_off, breathe_on,
                     off_time, on_time, prescale};
  assign accept_s = cfg_valid & ready_q;

  // Next-state and next-output computation; outputs are derived from the next state so
  // each beat appears on the cycle right after the edge that produced it.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    shadow_d  = shadow_q;
    exe_cap_d = exe_cap_q;
    ready_d   = 1'b0;
    exe_d     = exe_q;
    done_d    = 1'b0;
    cs_d      = 1'b0;
    den_d     = 1'b0;
    addr_d    = 4'h0;
    dat_d     = 8'h00;

    case (state_q)
      ST_IDLE, ST_ARM: begin
        // ARM is the first ready cycle, so a held request is taken without a gap.
        if (accept_s) begin
          state_d   = ST_WRITE;
          beat_d    = 4'd0;
          shadow_d  = cfg_in_s;
          exe_cap_d = exe_en;
          exe_d     = 1'b0;
        end else begin
          state_d   = ST_IDLE;
          beat_d    = 4'd0;
          ready_d   = 1'b1;
        end
      end
      ST_WRITE: begin
        if (beat_q == LAST_BEAT) begin
          state_d = ST_ARM;
          beat_d  = 4'd0;
          exe_d   = exe_cap_q;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end else if (beat_q < LAST_BEAT) begin
          state_d = ST_WRITE;
          beat_d  = beat_q + 4'd1;
        end else begin
          state_d = ST_IDLE;
          beat_d  = 4'd0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = 4'd0;
        ready_d = 1'b1;
        exe_d   = 1'b0;
      end
    endcase

    if (state_d == ST_WRITE) begin
      cs_d   = 1'b1;
      den_d  = 1'b1;
      addr_d = beat_addr(beat_d);
      dat_d  = beat_data(shadow_d, beat_d);
    end else begin
      cs_d   = 1'b0;
      den_d  = 1'b0;
      addr_d = 4'h0;
      dat_d  = 8'h00;
    end
  end

  // State, shadow image and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      beat_q    <= 4'd0;
      shadow_q  <= '0;
      exe_cap_q <= 1'b0;
      ready_q   <= 1'b1;
      cs_q      <= 1'b0;
      den_q     <= 1'b0;
      addr_q    <= 4'h0;
      dat_q     <= 8'h00;
      exe_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      shadow_q  <= shadow_d;
      exe_cap_q <= exe_cap_d;
      ready_q   <= ready_d;
      cs_q      <= cs_d;
      den_q     <= den_d;
      addr_q    <= addr_d;
      dat_q     <= dat_d;
      exe_q     <= exe_d;
      done_q    <= done_d;
    end
  end

  assign cfg_ready = ready_q;
  assign ledd_cs   = cs_q;
  assign ledd_den  = den_q;
  assign ledd_addr = addr_q;
  assign ledd_dat  = dat_q;
  assign ledd_exe  = exe_q;
  assign done      = done_q;

endmodule

// File: tb/tb_led_cfg_seq.sv
// Randomized bench for led_cfg_seq against a cycle-count reference model of the load
// timeline (elapsed cycles since handshake -> expected bus activity).
module tb_led_cfg_seq;

  logic       clk = 1'b0;
  logic       resetn;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] pwm_r, pwm_g, pwm_b;
  logic [7:0] prescale, on_time, off_time, breathe_on, breathe_off, ctrl0;
  logic       exe_en;
  logic       ledd_cs, ledd_den;
  logic [3:0] ledd_addr;
  logic [7:0] ledd_dat;
  logic       ledd_exe;
  logic       done;

  int checks   = 0;
  int failures = 0;

  // Reference model: ph = cycles since the accepting edge (0 = idle, 1..9 beats, 10 arm).
  int         ph = 0;
  logic [7:0] cap [9];
  logic       cap_exe = 1'b0;
  logic       m_exe   = 1'b0;
  int         dut_beats = 0;
  logic [3:0] addr_tbl [9] = '{4'h9, 4'hA, 4'hB, 4'h5, 4'h6, 4'h1, 4'h2, 4'h3, 4'h8};

  always #5 clk = ~clk;

  led_cfg_seq #(.CLK_PASS(0)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .pwm_r      (pwm_r),
    .pwm_g      (pwm_g),
    .pwm_b      (pwm_b),
    .prescale   (prescale),
    .on_time    (on_time),
    .off_time   (off_time),
    .breathe_on (breathe_on),
    .breathe_off(breathe_off),
    .ctrl0      (ctrl0),
    .exe_en     (exe_en),
    .ledd_cs    (ledd_cs),
    .ledd_den   (ledd_den),
    .ledd_addr  (ledd_addr),
    .ledd_dat   (ledd_dat),
    .ledd_exe   (ledd_exe),
    .done       (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!resetn) begin
      ph    = 0;
      m_exe = 1'b0;
    end else if (cfg_valid && (ph == 0 || ph == 10)) begin
      cap[0] = prescale;    cap[1] = on_time;   cap[2] = off_time;
      cap[3] = breathe_on;  cap[4] = breathe_off;
      cap[5] = pwm_r;       cap[6] = pwm_g;     cap[7] = pwm_b;
      cap[8] = ctrl0;
      cap_exe = exe_en;
      ph      = 1;
      m_exe   = 1'b0;
    end else if (ph >= 1 && ph <= 9) begin
      ph = ph + 1;
      if (ph == 10) m_exe = cap_exe;
    end else begin
      ph = 0;
    end
  endtask

  task automatic check_outputs();
    bit wr;
    wr = (ph >= 1 && ph <= 9);
    check_eq("cs",    32'(ledd_cs),   32'(wr));
    check_eq("den",   32'(ledd_den),  32'(wr));
    check_eq("addr",  32'(ledd_addr), wr ? 32'(addr_tbl[ph-1]) : 32'd0);
    check_eq("dat",   32'(ledd_dat),  wr ? 32'(cap[ph-1]) : 32'd0);
    check_eq("done",  32'(done),      32'(ph == 10));
    check_eq("ready", 32'(cfg_ready), 32'(ph == 0 || ph == 10));
    check_eq("exe",   32'(ledd_exe),  32'(m_exe));
    if (ledd_cs) dut_beats++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive_rand();
    pwm_r       = 8'($urandom);
    pwm_g       = 8'($urandom);
    pwm_b       = 8'($urandom);
    prescale    = 8'($urandom);
    on_time     = 8'($urandom);
    off_time    = 8'($urandom);
    breathe_on  = 8'($urandom);
    breathe_off = 8'($urandom);
    ctrl0       = 8'($urandom);
    exe_en      = 1'($urandom_range(0, 1));
  endtask

  initial begin
    resetn    = 1'b0;
    cfg_valid = 1'b0;
    drive_rand();
    repeat (2) @(negedge clk);
    check_outputs();
    resetn = 1'b1;
    step();

    // Single directed load with exe_en=1.
    prescale = 8'h3F; ctrl0 = 8'hC0; pwm_r = 8'h10; pwm_g = 8'h20; pwm_b = 8'h30;
    exe_en = 1'b1; cfg_valid = 1'b1;
    dut_beats = 0;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 11; i++) step();
    check_eq("single_beats", 32'(dut_beats), 32'd9);

    // Back-to-back loads with cfg_valid held and data churning every cycle.
    cfg_valid = 1'b1;
    for (int i = 0; i < 25; i++) begin
      drive_rand();
      pwm_g = ~pwm_g;
      step();
    end
    cfg_valid = 1'b0;
    for (int i = 0; i < 12; i++) step();

    // exe_en=0 load after an armed load.
    drive_rand();
    exe_en = 1'b0; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      pwm_g = ~pwm_g;
      step();
    end

    // Requests while busy are ignored.
    drive_rand();
    cfg_valid = 1'b1;
    dut_beats = 0;
    step();
    for (int i = 0; i < 13; i++) begin
      drive_rand();
      cfg_valid = (ph >= 1 && ph <= 9) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    check_eq("busy_ignore_beats", 32'(dut_beats), 32'd9);

    // Reset during beat 4, then confirm nothing resumes.
    drive_rand();
    exe_en = 1'b1; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("at_beat4", 32'(ph), 32'd5);
    #1 resetn = 1'b0;
    #1 ph = 0; m_exe = 1'b0;
    check_outputs();
    step();
    step();
    resetn = 1'b1;
    dut_beats = 0;
    for (int i = 0; i < 12; i++) step();
    check_eq("post_reset_beats", 32'(dut_beats), 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive_rand();
      cfg_valid = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_cfg_seq.md
LED_CFG_SEQ -- requirements
Module: led_cfg_seq

Interface
REQ-001 SHALL have parameter CLK_PASS, default 0, reserved and unused; the block SHALL compile with any value.
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge; the parent ties the RGB PWM block's LEDDCLK to this clock.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cfg_valid  input  1  configuration request.
REQ-005 SHALL have port cfg_ready  output  1  block idle, request accepted when cfg_valid and cfg_ready are both high.
REQ-006 SHALL have ports pwm_r, pwm_g, pwm_b  input  8 each  duty values for the red, green and blue channels.
REQ-007 SHALL have ports prescale, on_time, off_time, breathe_on, breathe_off, ctrl0  input  8 each  LEDDBR, LEDDONR, LEDDOFR, LEDDBCRR, LEDDBCFR and LEDDCR0 contents.
REQ-008 SHALL have port exe_en  input  1  LEDDEXE level to apply after the load completes.
REQ-009 SHALL have ports ledd_cs and ledd_den  output  1 each  register-write strobes.
REQ-010 SHALL have port ledd_addr  output  4  register address.
REQ-011 SHALL have port ledd_dat  output  8  register write data.
REQ-012 SHALL have port ledd_exe  output  1  drives LEDDEXE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a load completes.

Function
REQ-014 SHALL implement a state machine with states IDLE, WRITE and ARM.
REQ-015 IDLE: cfg_ready=1; on handshake SHALL capture all data inputs and exe_en into shadow registers, clear beat index to 0, and go to WRITE.
REQ-016 WRITE: SHALL issue exactly 9 consecutive single-cycle write beats, one per clk, with ledd_cs=1 and ledd_den=1.
REQ-017 Beat order (index: addr/data) SHALL be 0:0x9/prescale, 1:0xA/on_time, 2:0xB/off_time, 3:0x5/breathe_on, 4:0x6/breathe_off, 5:0x1/pwm_r, 6:0x2/pwm_g, 7:0x3/pwm_b, 8:0x8/ctrl0.
REQ-018 After beat 8, SHALL go to ARM.
REQ-019 ARM: lasts one cycle; SHALL set ledd_exe to the captured exe_en, pulse done=1 and return to IDLE.
REQ-020 Timing: with the handshake on edge N, beats SHALL occupy cycles N+1..N+9; done=1 and the new ledd_exe SHALL appear in cycle N+10; cfg_ready SHALL be 1 again in cycle N+10.
REQ-021 ledd_exe SHALL be forced to 0 from cycle N+1 until ARM, so the LED IP never runs on a partial configuration.
REQ-022 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-023 Outside WRITE, ledd_cs=0, ledd_den=0, ledd_addr=0 and ledd_dat=0.
REQ-024 Data inputs SHALL be ignored while cfg_ready=0; input changes during a load SHALL NOT alter the beats.
REQ-025 A cfg_valid held high through ARM SHALL be accepted on the first IDLE cycle (N+10), with beats restarting in N+11 and no idle gap beyond the ARM cycle.
REQ-026 The beat index SHALL be 4 bits and SHALL never exceed 8; unused values SHALL return the FSM to IDLE with strobes low.

Reset
REQ-027 On resetn=0 the block SHALL immediately enter IDLE with cfg_ready=1 (from the first clock after release), ledd_cs=0, ledd_den=0, ledd_addr=0, ledd_dat=0, ledd_exe=0 and done=0.
REQ-028 Reset mid-load SHALL abandon the sequence, with no resume after release; ledd_exe SHALL remain 0 until a complete load finishes.

Verification
REQ-029 Single load: prescale=0x3F, ctrl0=0xC0, pwm_r/g/b=0x10/0x20/0x30, exe_en=1 -> 9 beats at addresses 9,A,B,5,6,1,2,3,8 with matching data; done and ledd_exe=1 at N+10.
REQ-030 Back-to-back: cfg_valid held for two loads -> second beat train starts at N+11, and ledd_exe drops to 0 at N+11.
REQ-031 Input churn: toggle pwm_g every cycle during WRITE -> beat 6 carries the value captured at handshake.
REQ-032 Reset at beat 4 -> strobes and ledd_exe go to 0 asynchronously; after release, cfg_ready=1 and no further beats occur.
REQ-033 exe_en=0 load -> ledd_exe stays 0 after ARM, and done still pulses once.
REQ-034 cfg_valid pulsed while cfg_ready=0 -> the request is ignored, with no extra beats.
